// File: rtl/ex_muldiv_stage_pkg.sv
// Shared EX-stage definitions: instruction codes, ALU/md op encodings, md-class predicate.
// The multiply/divide unit is built only when EX_MULDIV_EN is defined.
package ex_muldiv_stage_pkg;

  localparam int unsigned CODE_W = 6;

  localparam logic [CODE_W-1:0] IC_NOP   = 6'd0;
  localparam logic [CODE_W-1:0] IC_ADD   = 6'd1;
  localparam logic [CODE_W-1:0] IC_ADDU  = 6'd2;
  localparam logic [CODE_W-1:0] IC_SUB   = 6'd3;
  localparam logic [CODE_W-1:0] IC_SUBU  = 6'd4;
  localparam logic [CODE_W-1:0] IC_AND   = 6'd5;
  localparam logic [CODE_W-1:0] IC_OR    = 6'd6;
  localparam logic [CODE_W-1:0] IC_XOR   = 6'd7;
  localparam logic [CODE_W-1:0] IC_NOR   = 6'd8;
  localparam logic [CODE_W-1:0] IC_SLT   = 6'd9;
  localparam logic [CODE_W-1:0] IC_SLTU  = 6'd10;
  localparam logic [CODE_W-1:0] IC_SLL   = 6'd11;
  localparam logic [CODE_W-1:0] IC_SRL   = 6'd12;
  localparam logic [CODE_W-1:0] IC_SRA   = 6'd13;
  localparam logic [CODE_W-1:0] IC_ADDI  = 6'd14;
  localparam logic [CODE_W-1:0] IC_ADDIU = 6'd15;
  localparam logic [CODE_W-1:0] IC_ANDI  = 6'd16;
  localparam logic [CODE_W-1:0] IC_ORI   = 6'd17;
  localparam logic [CODE_W-1:0] IC_XORI  = 6'd18;
  localparam logic [CODE_W-1:0] IC_SLTI  = 6'd19;
  localparam logic [CODE_W-1:0] IC_SLTIU = 6'd20;
  localparam logic [CODE_W-1:0] IC_LUI   = 6'd21;
  localparam logic [CODE_W-1:0] IC_LW    = 6'd22;
  localparam logic [CODE_W-1:0] IC_SW    = 6'd23;
  localparam logic [CODE_W-1:0] IC_MULT  = 6'd24;
  localparam logic [CODE_W-1:0] IC_MULTU = 6'd25;
  localparam logic [CODE_W-1:0] IC_DIV   = 6'd26;
  localparam logic [CODE_W-1:0] IC_DIVU  = 6'd27;
  localparam logic [CODE_W-1:0] IC_MFHI  = 6'd28;
  localparam logic [CODE_W-1:0] IC_MFLO  = 6'd29;
  localparam logic [CODE_W-1:0] IC_MTHI  = 6'd30;
  localparam logic [CODE_W-1:0] IC_MTLO  = 6'd31;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI, ALU_ZERO
  } alu_op_e;

  typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_op_e;

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

  // Instructions that touch HI/LO or the multiply/divide unit.
  function automatic logic is_md_class(input logic [CODE_W-1:0] code);
    case (code)
      IC_MULT, IC_MULTU, IC_DIV, IC_DIVU,
      IC_MFHI, IC_MFLO, IC_MTHI, IC_MTLO: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ex_muldiv_stage_muldiv_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO and the latency counter.
// Present only when EX_MULDIV_EN is defined.
`ifdef EX_MULDIV_EN
module muldiv_unit
  import ex_muldiv_stage_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  md_op_e           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  md_state_e          state, state_next;
  logic [CNT_W-1:0]   cnt;
  md_op_e             op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               done;
  logic               signed_op, a_neg, b_neg;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic [WIDTH-1:0]   a_mag, b_mag, q_mag, r_mag, res_hi, res_lo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= MD_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      MD_IDLE: if (start) state_next = MD_BUSY;
      MD_BUSY: if (cnt == CNT_W'(1)) state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
  end

  always_comb begin
    busy = (cnt != '0);
    done = (state == MD_BUSY) && (cnt == CNT_W'(1));
  end

  // Signed ops work on magnitudes; min / -1 falls out as quotient = min, remainder 0.
  always_comb begin
    signed_op = (op_q == MD_MULT) || (op_q == MD_DIV);
    a_neg     = signed_op && a_q[WIDTH-1];
    b_neg     = signed_op && b_q[WIDTH-1];
    a_ext     = {{WIDTH{a_neg}}, a_q};
    b_ext     = {{WIDTH{b_neg}}, b_q};
    prod      = a_ext * b_ext;
    a_mag     = a_neg ? -a_q : a_q;
    b_mag     = b_neg ? -b_q : b_q;
    q_mag     = '0;
    r_mag     = '0;
    res_hi    = '0;
    res_lo    = '0;
    if (b_q != '0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    if ((op_q == MD_MULT) || (op_q == MD_MULTU)) begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else if (b_q == '0) begin
      res_hi = a_q;
      res_lo = '1;
    end else begin
      res_hi = a_neg ? -r_mag : r_mag;
      res_lo = (a_neg ^ b_neg) ? -q_mag : q_mag;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      op_q <= MD_MULT;
      a_q  <= '0;
      b_q  <= '0;
      hi   <= '0;
      lo   <= '0;
    end else begin
      if (start) begin
        op_q <= op;
        a_q  <= a;
        b_q  <= b;
        cnt  <= ((op == MD_MULT) || (op == MD_MULTU)) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
      end else if (busy) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (done) begin
        hi <= res_hi;
        lo <= res_lo;
      end else begin
        if (wr_hi) hi <= a;
        if (wr_lo) lo <= a;
      end
    end
  end

endmodule
`endif

// File: rtl/ex_muldiv_stage.sv
// Pipelined MIPS execute stage: ALU, registered EX/MEM output with valid/ready, flush,
// and an optional multi-cycle multiply/divide unit enabled by EX_MULDIV_EN.
module ex_muldiv_stage
  import ex_muldiv_stage_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      instr_in,
  input  logic [5:0]       instr_code_in,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic [WIDTH-1:0] ext_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      pc_out,
  output logic [31:0]      instr_out,
  output logic [5:0]       instr_code_out,
  output logic [WIDTH-1:0] result_out,
  output logic [WIDTH-1:0] rt_data_out,
  output logic             md_busy
);

  logic             md_class, accept, use_imm;
  alu_op_e          alu_op;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] alu_b, alu_y, ex_result, hi, lo;

  assign shamt    = instr_in[10:6];
  assign md_class = is_md_class(instr_code_in);
  assign in_ready = (!out_valid || out_ready) && !(md_class && md_busy) && !flush;
  assign accept   = in_valid && in_ready;

  // Control decoder: ALU op and B-operand source.
  always_comb begin
    alu_op  = ALU_ZERO;
    use_imm = 1'b0;
    case (instr_code_in)
      IC_ADD, IC_ADDU:          alu_op = ALU_ADD;
      IC_SUB, IC_SUBU:          alu_op = ALU_SUB;
      IC_AND:                   alu_op = ALU_AND;
      IC_OR:                    alu_op = ALU_OR;
      IC_XOR:                   alu_op = ALU_XOR;
      IC_NOR:                   alu_op = ALU_NOR;
      IC_SLT:                   alu_op = ALU_SLT;
      IC_SLTU:                  alu_op = ALU_SLTU;
      IC_SLL:                   alu_op = ALU_SLL;
      IC_SRL:                   alu_op = ALU_SRL;
      IC_SRA:                   alu_op = ALU_SRA;
      IC_ADDI, IC_ADDIU,
      IC_LW, IC_SW:             begin alu_op = ALU_ADD;  use_imm = 1'b1; end
      IC_ANDI:                  begin alu_op = ALU_AND;  use_imm = 1'b1; end
      IC_ORI:                   begin alu_op = ALU_OR;   use_imm = 1'b1; end
      IC_XORI:                  begin alu_op = ALU_XOR;  use_imm = 1'b1; end
      IC_SLTI:                  begin alu_op = ALU_SLT;  use_imm = 1'b1; end
      IC_SLTIU:                 begin alu_op = ALU_SLTU; use_imm = 1'b1; end
      IC_LUI:                   begin alu_op = ALU_LUI;  use_imm = 1'b1; end
      default:                  alu_op = ALU_ZERO;
    endcase
  end

  assign alu_b = use_imm ? ext_imm : rt_data;

  // ALU; shifts act on the B operand by the instruction's shamt field.
  always_comb begin
    alu_y = '0;
    case (alu_op)
      ALU_ADD:  alu_y = rs_data + alu_b;
      ALU_SUB:  alu_y = rs_data - alu_b;
      ALU_AND:  alu_y = rs_data & alu_b;
      ALU_OR:   alu_y = rs_data | alu_b;
      ALU_XOR:  alu_y = rs_data ^ alu_b;
      ALU_NOR:  alu_y = ~(rs_data | alu_b);
      ALU_SLT:  alu_y = WIDTH'($signed(rs_data) < $signed(alu_b));
      ALU_SLTU: alu_y = WIDTH'(rs_data < alu_b);
      ALU_SLL:  alu_y = alu_b << shamt;
      ALU_SRL:  alu_y = alu_b >> shamt;
      ALU_SRA:  alu_y = WIDTH'($signed(alu_b) >>> shamt);
      ALU_LUI:  alu_y = alu_b << 16;
      default:  alu_y = '0;
    endcase
  end

  always_comb begin
    ex_result = alu_y;
    if (instr_code_in == IC_MFHI)      ex_result = hi;
    else if (instr_code_in == IC_MFLO) ex_result = lo;
    else if (md_class)                 ex_result = '0;
  end

`ifdef EX_MULDIV_EN
  logic   md_start;
  md_op_e md_op;

  always_comb begin
    md_op = MD_MULT;
    case (instr_code_in)
      IC_MULTU: md_op = MD_MULTU;
      IC_DIV:   md_op = MD_DIV;
      IC_DIVU:  md_op = MD_DIVU;
      default:  md_op = MD_MULT;
    endcase
  end

  assign md_start = accept && ((instr_code_in == IC_MULT) || (instr_code_in == IC_MULTU) ||
                               (instr_code_in == IC_DIV)  || (instr_code_in == IC_DIVU));

  muldiv_unit #(
    .WIDTH       (WIDTH),
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_muldiv (
    .clk   (clk),
    .reset (reset),
    .start (md_start),
    .op    (md_op),
    .a     (rs_data),
    .b     (rt_data),
    .wr_hi (accept && (instr_code_in == IC_MTHI)),
    .wr_lo (accept && (instr_code_in == IC_MTLO)),
    .busy  (md_busy),
    .hi    (hi),
    .lo    (lo)
  );
`else
  assign md_busy = 1'b0;
  assign hi      = '0;
  assign lo      = '0;
`endif

  // EX/MEM register; flush takes priority over both accept and drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || flush) begin
      out_valid      <= 1'b0;
      pc_out         <= '0;
      instr_out      <= '0;
      instr_code_out <= '0;
      result_out     <= '0;
      rt_data_out    <= '0;
    end else if (accept) begin
      out_valid      <= 1'b1;
      pc_out         <= pc_in;
      instr_out      <= instr_in;
      instr_code_out <= instr_code_in;
      result_out     <= ex_result;
      rt_data_out    <= rt_data;
    end else if (out_ready) begin
      out_valid      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Self-checking bench for ex_muldiv_stage; expectations follow EX_MULDIV_EN when defined.
module tb_ex_muldiv_stage;
  import ex_muldiv_stage_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;
`ifdef EX_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic         clk = 1'b0, reset = 1'b1, flush = 1'b0;
  logic         in_valid = 1'b0, out_ready = 1'b1;
  logic         in_ready, out_valid, md_busy;
  logic [31:0]  pc_in = '0, instr_in = '0, pc_out, instr_out;
  logic [5:0]   instr_code_in = '0, instr_code_out;
  logic [W-1:0] rs_data = '0, rt_data = '0, ext_imm = '0, result_out, rt_data_out;

  int          checks = 0, errors = 0;
  logic [31:0] hi_m = '0, lo_m = '0;
  logic [31:0] last_pc, last_instr;
  logic [5:0]  alu_codes [23] = '{IC_ADD, IC_ADDU, IC_SUB, IC_SUBU, IC_AND, IC_OR, IC_XOR,
                                  IC_NOR, IC_SLT, IC_SLTU, IC_SLL, IC_SRL, IC_SRA, IC_ADDI,
                                  IC_ADDIU, IC_ANDI, IC_ORI, IC_XORI, IC_SLTI, IC_SLTIU,
                                  IC_LUI, IC_LW, IC_SW};
  logic [5:0]  md_codes [4] = '{IC_MULT, IC_MULTU, IC_DIV, IC_DIVU};

  always #5 clk = ~clk;

  ex_muldiv_stage #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .instr_in(instr_in), .instr_code_in(instr_code_in),
    .rs_data(rs_data), .rt_data(rt_data), .ext_imm(ext_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc_out(pc_out), .instr_out(instr_out), .instr_code_out(instr_code_out),
    .result_out(result_out), .rt_data_out(rt_data_out), .md_busy(md_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] alu_model(input logic [5:0] code, input logic [31:0] rs,
                                            input logic [31:0] rt, input logic [31:0] imm,
                                            input logic [4:0] sh);
    int t;
    case (code)
      IC_ADD, IC_ADDU:                  return rs + rt;
      IC_ADDI, IC_ADDIU, IC_LW, IC_SW:  return rs + imm;
      IC_SUB, IC_SUBU:                  return rs - rt;
      IC_AND:                           return rs & rt;
      IC_ANDI:                          return rs & imm;
      IC_OR:                            return rs | rt;
      IC_ORI:                           return rs | imm;
      IC_XOR:                           return rs ^ rt;
      IC_XORI:                          return rs ^ imm;
      IC_NOR:                           return ~(rs | rt);
      IC_SLT:                           return (int'(rs) < int'(rt)) ? 32'd1 : 32'd0;
      IC_SLTI:                          return (int'(rs) < int'(imm)) ? 32'd1 : 32'd0;
      IC_SLTU:                          return (rs < rt) ? 32'd1 : 32'd0;
      IC_SLTIU:                         return (rs < imm) ? 32'd1 : 32'd0;
      IC_SLL:                           return rt << sh;
      IC_SRL:                           return rt >> sh;
      IC_SRA: begin t = int'(rt); t = t >>> sh; return 32'(t); end
      IC_LUI:                           return {imm[15:0], 16'h0000};
      default:                          return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] expect_result(input logic [5:0] code, input logic [31:0] rs,
                                                input logic [31:0] rt, input logic [31:0] imm,
                                                input logic [4:0] sh);
    if (code == IC_MFHI) return hi_m;
    if (code == IC_MFLO) return lo_m;
    if (code >= IC_MULT && code <= IC_MTLO) return 32'd0;
    return alu_model(code, rs, rt, imm, sh);
  endfunction

  // HI/LO architectural model: results as seen by a later MF* instruction.
  task automatic md_update(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    if (!MD_EN) return;
    sa = longint'(int'(a));
    sb = longint'(int'(b));
    case (code)
      IC_MULT:  begin p = 64'(sa * sb); hi_m = p[63:32]; lo_m = p[31:0]; end
      IC_MULTU: begin p = {32'd0, a} * {32'd0, b}; hi_m = p[63:32]; lo_m = p[31:0]; end
      IC_DIV:
        if (b == 0) begin lo_m = 32'hFFFF_FFFF; hi_m = a; end
        else begin q = sa / sb; r = sa % sb; lo_m = 32'(q); hi_m = 32'(r); end
      IC_DIVU:
        if (b == 0) begin lo_m = 32'hFFFF_FFFF; hi_m = a; end
        else begin lo_m = a / b; hi_m = a % b; end
      IC_MTHI:  hi_m = a;
      IC_MTLO:  lo_m = a;
      default:  ;
    endcase
  endtask

  task automatic issue(input logic [5:0] code, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] imm, input logic [4:0] sh, output int stalls);
    logic [31:0] ins;
    ins = $urandom;
    ins[10:6] = sh;
    instr_code_in = code;
    rs_data = rs;
    rt_data = rt;
    ext_imm = imm;
    pc_in = $urandom & 32'hFFFF_FFFC;
    instr_in = ins;
    in_valid = 1'b1;
    last_pc = pc_in;
    last_instr = ins;
    stalls = 0;
    @(negedge clk);
    while (!in_ready && stalls < 200) begin
      stalls++;
      @(negedge clk);
    end
    chk("accept", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run(input string tag, input logic [5:0] code, input logic [31:0] rs,
                     input logic [31:0] rt, input logic [31:0] imm, input logic [4:0] sh,
                     input int exp_stall);
    logic [31:0] exp_res;
    int stalls;
    exp_res = expect_result(code, rs, rt, imm, sh);
    issue(code, rs, rt, imm, sh, stalls);
    if (exp_stall >= 0) chk({tag, "_stall"}, stalls, exp_stall);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_result"}, result_out, exp_res);
    chk({tag, "_pc"}, pc_out, last_pc);
    chk({tag, "_instr"}, {instr_code_out, instr_out}, {code, last_instr});
    chk({tag, "_rt"}, rt_data_out, rt);
    if (code >= IC_MULT && code <= IC_DIVU) chk({tag, "_busy"}, md_busy, MD_EN);
    md_update(code, rs, rt);
  endtask

  initial begin
    int          st;
    logic [5:0]  c;
    logic [31:0] a, b;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_result", result_out, 0);
    chk("rst_busy", md_busy, 0);
    chk("rst_in_ready", in_ready, 1);
    reset = 1'b0;

    // Directed multiply/divide cases
    run("mult", IC_MULT, 32'hFFFF_FFFF, 32'h2, 0, 0, 0);
    run("mult_mfhi", IC_MFHI, 0, 0, 0, 0, MD_EN ? MC : 0);
    chk("plan_mult_hi", result_out, MD_EN ? 32'hFFFF_FFFF : 32'h0);
    run("mult_mflo", IC_MFLO, 0, 0, 0, 0, 0);
    chk("plan_mult_lo", result_out, MD_EN ? 32'hFFFF_FFFE : 32'h0);
    run("multu", IC_MULTU, 32'hFFFF_FFFF, 32'h2, 0, 0, 0);
    run("multu_mfhi", IC_MFHI, 0, 0, 0, 0, MD_EN ? MC : 0);
    chk("plan_multu_hi", result_out, MD_EN ? 32'h1 : 32'h0);
    run("multu_mflo", IC_MFLO, 0, 0, 0, 0, 0);
    run("div", IC_DIV, 32'hFFFF_FFF9, 32'h2, 0, 0, 0);
    run("div_mflo", IC_MFLO, 0, 0, 0, 0, MD_EN ? DC : 0);
    chk("plan_div_lo", result_out, MD_EN ? 32'hFFFF_FFFD : 32'h0);
    run("div_mfhi", IC_MFHI, 0, 0, 0, 0, 0);
    run("divu0", IC_DIVU, 32'h5, 32'h0, 0, 0, 0);
    run("divu0_mflo", IC_MFLO, 0, 0, 0, 0, MD_EN ? DC : 0);
    run("divu0_mfhi", IC_MFHI, 0, 0, 0, 0, 0);
    chk("plan_divu0_hi", result_out, MD_EN ? 32'h5 : 32'h0);
    run("divovf", IC_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
    run("divovf_mflo", IC_MFLO, 0, 0, 0, 0, MD_EN ? DC : 0);
    chk("plan_divovf_lo", result_out, MD_EN ? 32'h8000_0000 : 32'h0);
    run("divovf_mfhi", IC_MFHI, 0, 0, 0, 0, 0);
    run("mthi", IC_MTHI, 32'h1234_5678, 0, 0, 0, 0);
    run("mtlo", IC_MTLO, 32'h9ABC_DEF0, 0, 0, 0, 0);
    run("mt_mfhi", IC_MFHI, 0, 0, 0, 0, 0);
    run("mt_mflo", IC_MFLO, 0, 0, 0, 0, 0);

    // Random ALU traffic
    for (int i = 0; i < 40; i++) begin
      c = alu_codes[$urandom_range(0, 22)];
      run("alu", c, $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)), 0);
    end

    // Random multiply/divide followed by dependent reads
    for (int i = 0; i < 12; i++) begin
      c = md_codes[$urandom_range(0, 3)];
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'h0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run("md", c, a, b, 0, 0, 0);
      run("md_mfhi", IC_MFHI, 0, 0, 0, 0,
          MD_EN ? ((c == IC_MULT || c == IC_MULTU) ? MC : DC) : 0);
      run("md_mflo", IC_MFLO, 0, 0, 0, 0, 0);
    end

    // Backpressure: result holds for three cycles, then exactly one transfer
    @(posedge clk);
    #1;
    chk("bp_idle", out_valid, 0);
    out_ready = 1'b0;
    run("bp_addu", IC_ADDU, 32'h10, 32'h20, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_result", result_out, 32'h30);
      chk("bp_in_ready", in_ready, 0);
      @(posedge clk);
    end
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_still_valid", out_valid, 1);
    @(posedge clk);
    #1;
    chk("bp_released", out_valid, 0);

    // Flush with out_ready high blocks the new accept and empties the register
    run("fl_addu", IC_ADDU, 32'h5, 32'h6, 0, 0, 0);
    flush = 1'b1;
    in_valid = 1'b1;
    instr_code_in = IC_ADDU;
    @(negedge clk);
    chk("fl_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", out_valid, 0);
    @(posedge clk);
    #1;
    chk("fl_no_accept", out_valid, 0);

    // Reset two cycles into a divide discards it
    run("rst_div", IC_DIV, 32'd100, 32'd7, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy_before", md_busy, MD_EN);
    reset = 1'b1;
    #1;
    chk("rst_mid_busy", md_busy, 0);
    chk("rst_mid_valid", out_valid, 0);
    hi_m = '0;
    lo_m = '0;
    @(posedge clk);
    #1 reset = 1'b0;
    run("rst_mflo", IC_MFLO, 0, 0, 0, 0, 0);
    run("rst_mfhi", IC_MFHI, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ex_muldiv_stage.md
# ex_muldiv_stage

Parametrised execute stage for the pipelined MIPS core, succeeding the single-cycle combinational EX block. It adds a registered EX/MEM output with a valid/ready handshake, a multi-cycle multiply/divide unit with HI/LO registers, and a pipeline flush. It sits between the ID/EX register and the MEM stage, and stalls upstream while a HI/LO-dependent instruction meets a busy multiply/divide unit.

## Interface
- WIDTH, 32: datapath width; must be 8 or more.
- MULT_CYCLES, 5: multiply latency in cycles; must be 1 or more.
- DIV_CYCLES, 10: divide latency in cycles; must be 1 or more.

- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; clears the output register.
- in_valid  in  1  ID/EX holds an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- pc_in, instr_in  in  32  PC and raw instruction.
- instr_code_in  in  6  decoded instruction code from the shared header.
- rs_data, rt_data, ext_imm  in  WIDTH  operands.
- out_valid  out  1  EX/MEM register holds a result.
- out_ready  in  1  MEM stage consumes the result.
- pc_out, instr_out  out  32  registered PC and instruction.
- instr_code_out  out  6  registered instruction code.
- result_out, rt_data_out  out  WIDTH  registered result and store data.
- md_busy  out  1  multiply/divide unit is in flight.

## Operation
- Accept condition: in_valid && in_ready. On accept, the output register loads the instruction and out_valid=1.
- in_ready = (!out_valid || out_ready) && !(md_class && md_busy). md_class covers MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO.
- ALU instructions: control decoder selects the ALU op and the B source (rt_data or ext_imm). The shift amount comes from instr[10:6]. result_out receives the ALU output.
- MFHI/MFLO: result_out = HI or LO.
- MTHI/MTLO: HI or LO = rs_data at the accept edge.
- MULT/MULTU/DIV/DIVU on accept: operands latch and the cycle counter loads MULT_CYCLES or DIV_CYCLES. result_out=0.
- Multiply: the 2*WIDTH product splits into HI (upper half) and LO (lower half).
- Divide: LO = quotient and HI = remainder, truncating toward zero; remainder sign follows the dividend.
- Divide by zero: LO = all ones, HI = dividend.
- Signed overflow (min / -1): LO = min, HI = 0.
- Unit states: IDLE and BUSY. md_busy = (counter != 0). The counter decrements each cycle. On the 1->0 transition, HI/LO write and the unit returns to IDLE.
- flush: out_valid=0 next edge and no accept that cycle. It does not cancel an in-flight multiply/divide.
- Reset clears out_valid, all output registers, HI, LO and the counter, forcing md_busy=0. Reset mid-operation discards the computation; HI/LO stay 0.

## Timing
- ALU, MF*, MT* latency: 1 cycle from accept to out_valid.
- Multiply/divide accepted at cycle T: md_busy is high T+1..T+N. HI/LO become valid after the edge ending T+N. MFHI is accepted no earlier than T+N+1 and reads the new value.
- Backpressure (out_valid && !out_ready): output registers hold. The counter keeps running.
- Simultaneous flush and out_ready: flush wins.
- Simultaneous MT* accept and counter 1->0: impossible, because MT* is blocked while busy.

## Configuration
- EX_MULDIV_EN defined: behaviour as above.
- EX_MULDIV_EN undefined:
  - HI, LO, the counter and the multiply/divide unit are absent.
  - md_busy is tied to 0.
  - md_class instructions pass through with result_out=0 and never stall.

## Structure
- Shared package/header holds:
  - the instruction-code constants;
  - the ALU-op encoding;
  - the md-op encoding (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU);
  - the is_md_class function.
- The existing control decoder, 2:1 mux and ALU modules are reused unchanged.
- One sub-module: muldiv_unit, which owns HI/LO, the counter and the arithmetic. Its interface is start, op, a, b, busy, hi and lo.

## Test plan
- MULT 0xFFFFFFFF × 0x00000002, then MFHI and MFLO -> HI=0xFFFFFFFF, LO=0xFFFFFFFE. MFHI is stalled exactly MULT_CYCLES cycles.
- MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 5/0 -> LO=0xFFFFFFFF, HI=0x00000005.
- DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- ADDU result with out_ready=0 for 3 cycles -> result_out held stable, in_ready=0, one transfer on release. Same-cycle flush -> out_valid=0 next cycle.
- Reset asserted 2 cycles into a DIV -> md_busy=0 immediately. Subsequent MFLO returns 0 with no stall.
